// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector benches.
// Holds the frame FSM state encoding and a helper returning the frame length
// in clock cycles (preamble + payload + stop bit).
package serial_pattern_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PRE  = 2'b01,
        DATA = 2'b10,
        STOP = 2'b11
    } tx_state_t;

    function automatic int frame_len(input int pre_w, input int data_w);
        return pre_w + data_w + 1;
    endfunction

endpackage

// File: rtl/serial_pattern_tx_piso.sv
// Parallel-in serial-out shift register, MSB first; load wins over shift.
// Ports: clk, reset (sync, active-low), load/shift enables, din word in,
//        msb = current most significant bit (next serial bit).
module serial_pattern_tx_piso #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
);

    logic [DATA_W-1:0] sreg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= sreg << 1;
        end
    end

    assign msb = sreg[DATA_W-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial frame transmitter: preamble, payload MSB-first, stop bit.
// Ports: clk, reset (sync, active-low), din/din_valid/din_ready handshake,
//        x_out/x_en serial stream, busy (not idle), done (stop-bit cycle pulse).
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int              DATA_W  = 8,
    parameter int              PRE_W   = 2,
    parameter logic [PRE_W-1:0] PRE_PAT = 2'b11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              x_out,
    output logic              x_en,
    output logic              busy,
    output logic              done
);

    localparam int MAX_W = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W) + 1;
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;      // bits remaining in the current state after this one
    logic [PRE_W-1:0] pre_sr;   // preamble bits still to be sent, MSB next
    logic             accept;
    logic             sreg_shift;
    logic             sreg_msb;

    // Ready only depends on state so the upstream sees a stable, glitch-free ready.
    assign din_ready = (state == IDLE) || (state == STOP);
    assign accept    = din_valid && din_ready;

    // The payload MSB is copied to x_out whenever a data bit is being registered:
    // on entry to DATA and on every DATA cycle except the last.
    assign sreg_shift = ((state == PRE)  && (cnt == '0)) ||
                        ((state == DATA) && (cnt != '0));

    serial_pattern_tx_piso #(.DATA_W(DATA_W)) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (sreg_shift),
        .din   (din),
        .msb   (sreg_msb)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            pre_sr <= '0;
            x_out  <= 1'b0;
            x_en   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, STOP: begin
                    done <= 1'b0;
                    if (accept) begin
                        state  <= PRE;
                        cnt    <= PRE_LAST;
                        x_out  <= PRE_PAT[PRE_W-1];
                        pre_sr <= PRE_PAT << 1;
                        x_en   <= 1'b1;
                        busy   <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        cnt    <= '0;
                        x_out  <= 1'b0;
                        x_en   <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                PRE: begin
                    if (cnt == '0) begin
                        state <= DATA;
                        cnt   <= DATA_LAST;
                        x_out <= sreg_msb;
                    end else begin
                        cnt    <= cnt - 1'b1;
                        x_out  <= pre_sr[PRE_W-1];
                        pre_sr <= pre_sr << 1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        state <= STOP;
                        cnt   <= '0;
                        x_out <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt   <= cnt - 1'b1;
                        x_out <= sreg_msb;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
module tb_serial_pattern_tx;
    import serial_pattern_tx_pkg::*;

    localparam int DATA_W = 8;
    localparam int PRE_W  = 2;
    localparam logic [PRE_W-1:0] PRE_PAT = 2'b11;
    localparam int FL = frame_len(PRE_W, DATA_W);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              din_valid = 1'b0;
    logic              din_ready, x_out, x_en, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_pattern_tx #(.DATA_W(DATA_W), .PRE_W(PRE_W), .PRE_PAT(PRE_PAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x_out     (x_out),
        .x_en      (x_en),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame model: position within the current frame (-1 = idle), advanced from
    // the handshake rules and the frame length alone.
    int                m_pos = -1;
    logic [DATA_W-1:0] m_word = '0;

    always @(posedge clk) begin
        logic m_ready;
        m_ready = (m_pos < 0) || (m_pos == FL - 1);
        if (!reset) begin
            m_pos = -1;
        end else if (din_valid && m_ready) begin
            m_pos  = 0;
            m_word = din;
        end else if (m_pos >= 0) begin
            m_pos = (m_pos == FL - 1) ? -1 : m_pos + 1;
        end
    end

    function automatic logic [4:0] model_out(input int pos, input logic [DATA_W-1:0] w);
        logic xb;
        logic rdy;
        if (pos < 0) return 5'b00001;   // {x_out,x_en,busy,done,din_ready}
        if (pos < PRE_W)               xb = PRE_PAT[PRE_W-1-pos];
        else if (pos < PRE_W + DATA_W) xb = w[DATA_W-1-(pos-PRE_W)];
        else                           xb = 1'b0;
        rdy = (pos == FL - 1);
        return {xb, 1'b1, 1'b1, rdy, rdy};
    endfunction

    always @(negedge clk) begin
        chk("cycle_outputs", {59'd0, x_out, x_en, busy, done, din_ready},
            {59'd0, model_out(m_pos, m_word)});
    end

    // "10" sequence detector fed from x_out (Mealy: y = previous bit 1, current 0).
    logic det_prev = 1'b0;
    logic det_y;
    always @(posedge clk) det_prev <= reset ? x_out : 1'b0;
    assign det_y = det_prev & ~x_out;

    // Captured stream while x_en is high.
    bit s_q[$];
    bit d_q[$];
    bit y_q[$];
    always @(negedge clk) begin
        if (x_en) begin
            s_q.push_back(x_out);
            d_q.push_back(done);
            y_q.push_back(det_y);
        end
    end

    function automatic logic [63:0] q2v(input bit q[$]);
        logic [63:0] v;
        v = '0;
        foreach (q[i]) v = {v[62:0], q[i]};
        return v;
    endfunction

    task automatic clear_q();
        s_q.delete();
        d_q.delete();
        y_q.delete();
    endtask

    task automatic send(input logic [DATA_W-1:0] w);
        int n;
        n = 0;
        @(negedge clk);
        din       = w;
        din_valid = 1'b1;
        while (!din_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", 64'(n >= 100), 64'd0);
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || x_en) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(n >= 100), 64'd0);
    endtask

    initial begin
        // Reset held with din_valid asserted: nothing captured.
        din       = 8'hAA;
        din_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {60'd0, x_out, x_en, busy, done}, 64'd0);
        chk("reset_ready", 64'(din_ready), 64'd1);
        reset     = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 64'(din_ready), 64'd1);
        chk("post_reset_no_frame", 64'(x_en), 64'd0);

        // Single frame A5.
        clear_q();
        send(8'hA5);
        wait_idle();
        chk("a5_len", 64'(s_q.size()), 64'd11);
        chk("a5_stream", q2v(s_q), 64'(11'b11_10100101_0));
        chk("a5_done", q2v(d_q), 64'(11'b00000000001));

        // Back-to-back FF then 00 presented during the first frame.
        clear_q();
        send(8'hFF);
        send(8'h00);
        wait_idle();
        chk("b2b_len", 64'(s_q.size()), 64'd22);
        chk("b2b_stream", q2v(s_q), 64'(22'b11_11111111_0_11_00000000_0));
        chk("b2b_done", q2v(d_q), 64'(22'b00000000001_00000000001));

        // Valid held from mid-DATA: ignored until the STOP cycle.
        clear_q();
        send(8'hA5);
        repeat (4) @(negedge clk);
        send(8'h3C);
        wait_idle();
        chk("ign_stream", q2v(s_q), 64'(22'b11_10100101_0_11_00111100_0));

        // Reset at the 4th data bit aborts the frame.
        clear_q();
        send(8'hA5);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {60'd0, x_out, x_en, busy, done}, 64'd0);
        chk("abort_partial_len", 64'(s_q.size()), 64'd6);
        chk("abort_no_done", q2v(d_q), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        clear_q();
        send(8'h81);
        wait_idle();
        chk("after_abort_stream", q2v(s_q), 64'(11'b11_10000001_0));
        chk("after_abort_done", q2v(d_q), 64'(11'b00000000001));

        // Detector loopback: y fires on the 1->0 after the payload MSB.
        clear_q();
        send(8'h80);
        wait_idle();
        chk("loop_stream", q2v(s_q), 64'(11'b11_10000000_0));
        chk("loop_y", q2v(y_q), 64'(11'b00010000000));

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
